// File: rtl/hdlc_chk_pkg.sv
// Shared types and constants for the HDLC receive-path run-time checker.
package hdlc_chk_pkg;

  typedef enum int unsigned {
    CHK_FLAG  = 0,
    CHK_ABORT = 1,
    CHK_EOF   = 2,
    CHK_OVF   = 3,
    N_CHK     = 4
  } chk_e;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'h7F;
  localparam logic [7:0] IDLE_PAT  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FRAME    = 2'd1,
    OVF_DONE = 2'd2
  } frm_state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/hdlc_rx_checker_if.sv
// Bundle of Rx status strobes, checker controls and checker results.
interface hdlc_rx_checker_if import hdlc_chk_pkg::*; #(
  parameter int unsigned CNT_W = 16
);
  logic                     Rx;
  logic                     Rx_FlagDetect;
  logic                     Rx_ValidFrame;
  logic                     Rx_AbortDetect;
  logic                     Rx_AbortSignal;
  logic                     Rx_EoF;
  logic                     Rx_NewByte;
  logic                     Rx_Overflow;
  logic [N_CHK-1:0]         ChkEn;
  logic                     ClrErr;
  logic [N_CHK-1:0]         ErrFlags;
  logic [N_CHK*CNT_W-1:0]   ErrCntVec;
  logic [CNT_W-1:0]         ErrCnt;
  logic                     FrameActive;

  modport master (
    output Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal, Rx_EoF,
           Rx_NewByte, Rx_Overflow, ChkEn, ClrErr,
    input  ErrFlags, ErrCntVec, ErrCnt, FrameActive
  );

  modport slave (
    input  Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal, Rx_EoF,
           Rx_NewByte, Rx_Overflow, ChkEn, ClrErr,
    output ErrFlags, ErrCntVec, ErrCnt, FrameActive
  );
endinterface

// File: rtl/hdlc_pattern_det.sv
// Serial 8-bit pattern matcher for flag, abort and idle sequences; usable on Rx or Tx.
module hdlc_pattern_det import hdlc_chk_pkg::*; (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic flag_o,
  output logic abort_o,
  output logic idle_o
);

  logic [7:0] sr_q, sr_d;

  always_comb begin
    sr_d = {sr_q[6:0], rx_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign flag_o  = (sr_q == FLAG_PAT);
  assign abort_o = (sr_q == ABORT_PAT);
  assign idle_o  = (sr_q == IDLE_PAT);

endmodule

// File: rtl/hdlc_rx_checker.sv
// HDLC Rx protocol checker: flag latency, abort, end-of-frame and overflow rules with
// saturating per-check error counters and sticky flags.
module hdlc_rx_checker import hdlc_chk_pkg::*; #(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned OVF_BYTES = 130,
  parameter int unsigned CNT_W     = 16
) (
  input logic               Clk,
  input logic               Rst,
  hdlc_rx_checker_if.slave  chk
);

  localparam int unsigned NC = N_CHK;
  localparam int unsigned BW = $clog2(OVF_BYTES + 1);
  localparam logic [BW-1:0] OVF_MAX = BW'(OVF_BYTES);

  logic flag_m, abort_m, idle_m;

  hdlc_pattern_det u_pat (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .rx_i    (chk.Rx),
    .flag_o  (flag_m),
    .abort_o (abort_m),
    .idle_o  (idle_m)
  );

  logic [FLAG_LAT-1:0]       pend_q, pend_d;
  logic                      abort_pend_q, abort_pend_d;
  logic                      vf_q, vf_fall;
  logic                      eof_pend_q, eof_pend_d;
  logic                      ovf_pend_q, ovf_pend_d;
  logic                      fell_q, fell_d;
  frm_state_e                state_q, state_d;
  logic [BW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [NC-1:0]             err_raw, err;
  logic [NC-1:0]             flags_q, flags_d;
  logic [NC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]          tot_q, tot_d;
  logic [CNT_W:0]            tot_sum;

  // Expectation pipes and frame FSM.
  always_comb begin
    pend_d       = (pend_q << 1) | FLAG_LAT'(flag_m);
    abort_pend_d = chk.Rx_AbortDetect & chk.Rx_ValidFrame;
    vf_fall      = vf_q & ~chk.Rx_ValidFrame;
    eof_pend_d   = vf_fall;
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ovf_pend_d   = 1'b0;
    fell_d       = fell_q | vf_fall;
    unique case (state_q)
      IDLE: begin
        if (!idle_m && flag_m && !chk.Rx_ValidFrame) begin
          state_d    = FRAME;
          byte_cnt_d = '0;
          fell_d     = 1'b0;
        end
      end
      FRAME, OVF_DONE: begin
        // Repeated opening flags keep the frame; only a flag after a frame end closes it.
        if (!idle_m && (abort_m || (flag_m && fell_q))) begin
          state_d = IDLE;
          fell_d  = 1'b0;
        end else if (state_q == FRAME) begin
          if (byte_cnt_q >= OVF_MAX) begin
            ovf_pend_d = 1'b1;
            state_d    = OVF_DONE;
          end else if (chk.Rx_NewByte && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error evaluation and reporting.
  always_comb begin
    err_raw = {ovf_pend_q   & ~chk.Rx_Overflow,
               eof_pend_q   & ~chk.Rx_EoF,
               abort_pend_q & ~chk.Rx_AbortSignal,
               pend_q[FLAG_LAT-1] & ~chk.Rx_FlagDetect};
    err     = err_raw & chk.ChkEn;
    flags_d = chk.ClrErr ? '0 : (flags_q | err);
    for (int unsigned k = 0; k < NC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (chk.ClrErr) begin
        cnt_d[k] = '0;
      end else if (err[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    tot_sum = {1'b0, tot_q} + (CNT_W + 1)'(popcnt4(err));
    if (chk.ClrErr) begin
      tot_d = '0;
    end else if (tot_sum[CNT_W]) begin
      tot_d = '1;
    end else begin
      tot_d = tot_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend_q       <= '0;
      abort_pend_q <= 1'b0;
      vf_q         <= 1'b0;
      eof_pend_q   <= 1'b0;
      ovf_pend_q   <= 1'b0;
      fell_q       <= 1'b0;
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
      tot_q        <= '0;
    end else begin
      pend_q       <= pend_d;
      abort_pend_q <= abort_pend_d;
      vf_q         <= chk.Rx_ValidFrame;
      eof_pend_q   <= eof_pend_d;
      ovf_pend_q   <= ovf_pend_d;
      fell_q       <= fell_d;
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
      tot_q        <= tot_d;
    end
  end

  assign chk.ErrFlags    = flags_q;
  assign chk.ErrCntVec   = cnt_q;
  assign chk.ErrCnt      = tot_q;
  assign chk.FrameActive = (state_q == FRAME);

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Directed scoreboard bench for hdlc_rx_checker, built with 4-bit counters to reach saturation.
module tb_hdlc_rx_checker;
  import hdlc_chk_pkg::*;

  localparam int unsigned CW = 4;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hdlc_rx_checker_if #(.CNT_W(CW)) bus ();

  hdlc_rx_checker #(
    .FLAG_LAT  (2),
    .OVF_BYTES (130),
    .CNT_W     (CW)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .chk (bus)
  );

  typedef struct {
    string           tag;
    logic [3:0]      flags;
    logic [4*CW-1:0] vec;
    logic [CW-1:0]   cnt;
    logic            fa;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic sb_push(input string tag, input logic [3:0] f, input logic [4*CW-1:0] v,
                         input logic [CW-1:0] c, input logic fa);
    exp_t e;
    e.tag = tag; e.flags = f; e.vec = v; e.cnt = c; e.fa = fa;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    exp_t e;
    check_eq("sb_avail", 32'(sb_q.size()), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_eq({e.tag, ".flags"}, 32'(bus.ErrFlags), 32'(e.flags));
    check_eq({e.tag, ".vec"}, 32'(bus.ErrCntVec), 32'(e.vec));
    check_eq({e.tag, ".cnt"}, 32'(bus.ErrCnt), 32'(e.cnt));
    check_eq({e.tag, ".active"}, 32'(bus.FrameActive), 32'(e.fa));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    bus.Rx = 1'b0; bus.Rx_FlagDetect = 1'b0; bus.Rx_ValidFrame = 1'b0;
    bus.Rx_AbortDetect = 1'b0; bus.Rx_AbortSignal = 1'b0; bus.Rx_EoF = 1'b0;
    bus.Rx_NewByte = 1'b0; bus.Rx_Overflow = 1'b0; bus.ChkEn = 4'hF; bus.ClrErr = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    Rst = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.Rx = b[i];
      tick();
    end
    bus.Rx = 1'b0;
  endtask

  // Flag match in cycle t, FlagDetect required at t+2; optional abort window at t+1.
  task automatic send_flag(input logic fd_early, input logic fd_ok, input logic ab);
    shift_byte(FLAG_PAT);
    tick();
    bus.Rx_FlagDetect = fd_early;
    bus.Rx_AbortDetect = ab;
    bus.Rx_ValidFrame = ab;
    tick();
    bus.Rx_FlagDetect = fd_ok;
    bus.Rx_AbortDetect = 1'b0;
    tick();
    bus.Rx_FlagDetect = 1'b0;
  endtask

  task automatic eof_seq(input logic eof, input logic clr);
    bus.Rx_ValidFrame = 1'b1;
    tick();
    bus.Rx_ValidFrame = 1'b0;
    tick();
    bus.Rx_EoF = eof;
    bus.ClrErr = clr;
    tick();
    bus.Rx_EoF = 1'b0;
    bus.ClrErr = 1'b0;
  endtask

  task automatic frame_bytes(input int n, input logic ovf);
    send_flag(1'b0, 1'b1, 1'b0);
    bus.Rx_NewByte = 1'b1;
    repeat (n) tick();
    bus.Rx_NewByte = 1'b0;
    tick();
    bus.Rx_Overflow = ovf;
    tick();
    bus.Rx_Overflow = 1'b0;
  endtask

  initial begin
    Rst = 1'b0;
    do_reset();
    sb_push("reset", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    send_flag(1'b0, 1'b1, 1'b0);
    sb_push("flag_ok", 4'h0, 16'h0000, 4'd0, 1'b1); sb_pop_check();

    do_reset();
    send_flag(1'b0, 1'b0, 1'b0);
    sb_push("flag_miss", 4'h1, 16'h0001, 4'd1, 1'b1); sb_pop_check();

    do_reset();
    send_flag(1'b1, 1'b0, 1'b0);
    sb_push("flag_early", 4'h1, 16'h0001, 4'd1, 1'b1); sb_pop_check();

    do_reset();
    bus.Rx_ValidFrame = 1'b1; bus.Rx_AbortDetect = 1'b1; tick();
    bus.Rx_AbortDetect = 1'b0; tick();
    sb_push("abort_miss", 4'h2, 16'h0010, 4'd1, 1'b0); sb_pop_check();

    do_reset();
    bus.Rx_ValidFrame = 1'b1; bus.Rx_AbortDetect = 1'b1; tick();
    bus.Rx_AbortDetect = 1'b0; bus.Rx_AbortSignal = 1'b1; tick();
    bus.Rx_AbortSignal = 1'b0;
    sb_push("abort_ok", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    bus.Rx_AbortDetect = 1'b1; tick();
    bus.Rx_AbortDetect = 1'b0; tick();
    sb_push("abort_novf", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    eof_seq(1'b0, 1'b0);
    sb_push("eof_miss", 4'h4, 16'h0100, 4'd1, 1'b0); sb_pop_check();

    do_reset();
    eof_seq(1'b1, 1'b0);
    sb_push("eof_ok", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    bus.ChkEn = 4'b1011;
    eof_seq(1'b0, 1'b0);
    sb_push("eof_masked", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    eof_seq(1'b0, 1'b1);
    sb_push("clr_prio", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    frame_bytes(130, 1'b1);
    sb_push("ovf_ok", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    frame_bytes(130, 1'b0);
    bus.Rx_NewByte = 1'b1;
    repeat (200) tick();
    bus.Rx_NewByte = 1'b0;
    repeat (3) tick();
    sb_push("ovf_miss", 4'h8, 16'h1000, 4'd1, 1'b0); sb_pop_check();

    do_reset();
    frame_bytes(129, 1'b0);
    repeat (3) tick();
    sb_push("ovf_short", 4'h0, 16'h0000, 4'd0, 1'b1); sb_pop_check();

    do_reset();
    send_flag(1'b0, 1'b0, 1'b1);
    sb_push("flag_abort", 4'h3, 16'h0011, 4'd2, 1'b1); sb_pop_check();

    do_reset();
    send_flag(1'b0, 1'b1, 1'b0);
    eof_seq(1'b1, 1'b0);
    send_flag(1'b0, 1'b1, 1'b0);
    sb_push("frame_exit", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    send_flag(1'b0, 1'b1, 1'b0);
    shift_byte(ABORT_PAT);
    tick();
    tick();
    sb_push("abort_exit", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    do_reset();
    repeat (20) send_flag(1'b0, 1'b0, 1'b0);
    sb_push("saturate", 4'h1, 16'h000F, 4'd15, 1'b1); sb_pop_check();
    bus.ClrErr = 1'b1; tick(); bus.ClrErr = 1'b0;
    sb_push("clear", 4'h0, 16'h0000, 4'd0, 1'b1); sb_pop_check();

    do_reset();
    shift_byte(FLAG_PAT);
    tick();
    sb_push("pre_rst", 4'h0, 16'h0000, 4'd0, 1'b1); sb_pop_check();
    Rst = 1'b0;
    #1;
    sb_push("in_rst", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();
    tick();
    Rst = 1'b1;
    repeat (5) tick();
    sb_push("post_rst", 4'h0, 16'h0000, 4'd0, 1'b0); sb_pop_check();

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_checker.md
# hdlc_rx_checker

Synthesizable, parametrised run-time checker for the HDLC receive path. It samples the serial Rx line and the Rx status strobes, enforces four protocol rules in hardware: flag detect latency, abort signalling, end-of-frame and buffer overflow. Violations are reported through per-check saturating counters and sticky flags. It binds alongside the Rx module in the same way as the bench assertions, and can also be left in silicon as a debug monitor.

## Interface
Parameters:
- FLAG_LAT, 2: cycles from the last bit of a received flag to the required Rx_FlagDetect.
- OVF_BYTES, 130: count of Rx_NewByte pulses within a frame after which Rx_Overflow is required.
- CNT_W, 16: width of each error counter.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial receive line.
- Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal, Rx_EoF, Rx_NewByte, Rx_Overflow  in  1 each  DUT Rx status.
- ChkEn  in  4  per-check enable; bit index from package enum.
- ClrErr  in  1  synchronous clear of counters and sticky flags.
- ErrFlags  out  4  sticky per-check failure flags.
- ErrCntVec  out  4*CNT_W  per-check error counters; check k occupies bits [k*CNT_W +: CNT_W].
- ErrCnt  out  CNT_W  total error count.
- FrameActive  out  1  frame FSM in FRAME state.

## Operation
- Pattern shift register: sr <= {sr[6:0], Rx} each cycle, oldest bit at MSB. Reset value 8'h00.
- Pattern matches: flag when sr == 8'h7E; abort when sr == 8'h7F; idle when sr == 8'hFF.
- CHK_FLAG: a flag match at cycle t pushes a 1 into a FLAG_LAT-deep pending pipe. At pipe output, pending && !Rx_FlagDetect is an error. Overlapping expectations are tracked independently.
- CHK_ABORT: Rx_AbortDetect && Rx_ValidFrame at t requires Rx_AbortSignal at t+1.
- CHK_EOF: Rx_ValidFrame registered high at t-1 and low at t requires Rx_EoF at t+1.
- CHK_OVF uses the frame FSM:
  - IDLE -> FRAME on a flag match while Rx_ValidFrame is low. The byte counter clears.
  - In FRAME, each Rx_NewByte increments the byte counter (width $clog2(OVF_BYTES+1), saturating).
  - When the counter reaches OVF_BYTES, Rx_Overflow is required the next cycle. The state then moves to OVF_DONE. Only one check is made per frame.
  - FRAME or OVF_DONE -> IDLE on an abort match, or on a flag match that follows a Rx_ValidFrame fall.
- A check whose ChkEn bit is 0 neither counts nor sets its flag. Its internal pipes and FSM still run.
- Error counters saturate at all-ones. ErrCnt adds 0..4 simultaneous failures in one cycle and saturates.
- ClrErr zeroes the counters and flags in the next cycle. It has priority over same-cycle errors. Pipes and FSM are unaffected.

## Timing
- Reset values: ErrFlags=0, ErrCntVec=0, ErrCnt=0, FrameActive=0. Internally, sr=0, pending pipe=0, FSM=IDLE, byte count=0.
- An error is detected in the evaluation cycle. The counter and flag update on the next rising edge, so there is 1 cycle of reporting latency.
- Reset asserted mid-frame discards all pending expectations. No error is reported for them.
- Flag detection begins 8 cycles after reset release. Because sr resets to 0, no false flag is produced.
- A flag match and an abort match cannot coincide. An idle match has no check; it only keeps the FSM in its current state.
- Counter at saturation with a further Rx_NewByte: no wrap.

## Structure
- Package hdlc_chk_pkg holds:
  - enum chk_e: CHK_FLAG=0, CHK_ABORT=1, CHK_EOF=2, CHK_OVF=3, plus N_CHK=4;
  - constants FLAG_PAT=8'h7E, ABORT_PAT=8'h7F and IDLE_PAT=8'hFF;
  - enum frm_state_e: IDLE, FRAME, OVF_DONE.
- Sub-module hdlc_pattern_det contains the shift register and the three match outputs. It is reusable on the Tx line.
- The top level holds the check logic, the frame FSM and the counters.

## Test plan
- Send 0,1,1,1,1,1,1,0 on Rx with Rx_FlagDetect pulsed at t+2 -> ErrCnt=0. Drive Rx_FlagDetect low instead -> ErrFlags[0]=1 and ErrCntVec[0]=1 one cycle later.
- Drive Rx_AbortDetect=1 and Rx_ValidFrame=1 for one cycle with Rx_AbortSignal held 0 -> ErrFlags[1]=1. Drive the same with Rx_ValidFrame=0 -> no error.
- Send a flag, 130 Rx_NewByte pulses inside the frame, then Rx_Overflow=1 -> no error. Omit the overflow -> ErrCntVec[3]=1, and no second error in the same frame.
- Cause abort and EoF failures in the same cycle -> ErrCnt increments by 2. With CNT_W=4, inject 20 flag errors -> ErrCntVec[0]=15.
- Clear ChkEn[2] and inject an EoF failure -> counters remain 0. Assert ClrErr after errors -> all zero the next cycle.
- Deassert Rst mid-frame with a flag expectation pending -> all outputs are 0 and no error is reported after release.
